dmg_timer: RTL
==============

# dmg_timer

Cycle-level model of the DMG timer unit: 16-bit free-running divider, TIMA counter with TMA reload, and TAC clock select, including the one-M-cycle overflow delay. It sits downstream of the register/flip-flop primitives and feeds the interrupt controller, using `irq` as the timer interrupt request. The CPU bus logic drives it through a 2-bit register-select write/read port.

## Interface
- `INITIAL_ZERO`, default 0: pre-reset contents of all state. 0 gives `$random`; 1 gives zero.
- `clk` input 1: T-cycle clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `addr` input 2: register select; 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- `wr` input 1: write strobe, sampled on the rising `clk` edge.
- `wdata` input 8: write data. X bits are replaced by `$random` when captured.
- `rdata` output 8: combinational read of the register selected by `addr`.
- `irq` output 1: timer interrupt request, a one-cycle pulse.

## Operation
- Reset: `div`=0, TIMA=0, TMA=0, TAC=0, `irq`=0, `sig_q`=0, state IDLE. Applies immediately, including mid-overflow.
- `div[15:0]` increments on every edge and wraps 0xFFFF to 0x0000. DIV reads `div[15:8]`. Any DIV write clears all 16 bits; the written value is ignored.
- TAC holds 3 bits and reads as `{5'b11111, tac}`. `tac[2]` is enable. `tac[1:0]` selects the divider tap: 00 selects `div[9]`, 01 selects `div[3]`, 10 selects `div[5]`, 11 selects `div[7]`.
- `sig = tac[2] & div[sel]`, registered each edge into `sig_q`. `tick = sig_q & ~sig`, a falling edge.
  - A DIV write or TAC write that drops `sig` produces a spurious tick. This is required and matches hardware.
- On `tick`, TIMA increments at the next edge.
- States:
  - IDLE: normal counting. A TIMA increment from 0xFF to 0x00 enters OVF with `cnt`=3.
  - OVF: TIMA holds 0x00 unless ticked; ticks still increment it. `cnt` decrements each edge. At `cnt`=0 the next edge enters RELOAD.
  - RELOAD: one cycle. On entry, TIMA is loaded with TMA and `irq` is 1. Next state is IDLE.
- Write priorities:
  - TIMA write in IDLE: TIMA takes `wdata` and any coincident tick is dropped.
  - TIMA write in OVF: TIMA takes `wdata`, state returns to IDLE, no reload and no `irq`.
  - TIMA write on the reload edge: ignored; the TMA value wins.
  - TMA write on the reload edge: the new `wdata` goes to both TMA and TIMA.
  - TMA/TAC writes otherwise: simple register loads.

## Timing
- The divider tap falls at edge n. TIMA increments at edge n+1.
- TIMA wraps to 0x00 at edge m. Reload happens at edge m+4, so TIMA reads 0x00 for 4 cycles.
- `irq` is high from edge m+4 to edge m+5, exactly one cycle. It is never asserted in any other cycle.
- A TIMA write at edges m+1, m+2 or m+3 cancels the reload and the IRQ. A TIMA write at edge m+4 is lost.
- `rdata` and `irq` drive through the shared timing-include output delay constant for this block. No other output latency applies.
- `reset` asserted between m and m+4 leaves `irq`=0 and TIMA=0.

## Structure
- Shared include `dmg_timer_defs`: register address constants, TAC select encoding, overflow delay constant (4), state encoding.
- Sub-module `dmg_timer_div` contains the 16-bit divider, the tap mux, `sig_q` and the falling-edge detector. It takes the DIV-clear and TAC inputs and outputs `div[15:8]` and `tick`.
- The top level holds TIMA, TMA, TAC, the overflow FSM/counter, the write decode and the read mux.

## Test plan
- Reset, then TAC=0b101 (tap `div[3]`): TIMA increments every 16 cycles. DIV reads 0x01 after 256 cycles.
- TMA=0xAB, TIMA=0xFF, TAC=0b101: after the wrap, TIMA reads 0x00 for 4 cycles, then 0xAB. `irq` is high for exactly one cycle at the reload edge.
- Same setup, TIMA write 0x42 two cycles after the wrap: TIMA=0x42, `irq` never asserts, state returns to IDLE.
- Same setup, TMA write 0x55 on the reload edge: TIMA=0x55 and TMA=0x55. A TIMA write on the reload edge instead leaves TIMA=TMA.
- TAC=0b100 (tap `div[9]`) with `div[9]`=1, then a DIV write: spurious tick, TIMA+1 one edge later. TAC written to 0b000 with the tap high also gives TIMA+1.
- Assert `reset` one cycle after a wrap: all outputs 0 immediately, no `irq` afterwards, DIV restarts from 0.

Source files
------------

// File: rtl/dmg_timer_pkg.sv
// Shared constants for the DMG timer: register map, TAC tap select, overflow delay, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dmg_timer_pkg;

  // Register select values on the CPU port
  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  // TAC[1:0] divider tap select
  localparam logic [1:0] TAC_SEL_DIV9 = 2'b00;
  localparam logic [1:0] TAC_SEL_DIV3 = 2'b01;
  localparam logic [1:0] TAC_SEL_DIV5 = 2'b10;
  localparam logic [1:0] TAC_SEL_DIV7 = 2'b11;

  // Edges from TIMA wrap to TMA reload; the counter starts one below so that
  // the reload lands on the edge after it reaches zero.
  localparam int         OVF_DELAY    = 4;
  localparam logic [1:0] OVF_CNT_INIT = 2'(OVF_DELAY - 1);

  // Overflow FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OVF    = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

endpackage

// File: rtl/dmg_timer_div.sv
// 16-bit free-running divider, TAC tap mux and falling-edge tick detector.
// Latency: tick is combinational, high the cycle after the gated tap falls.
// Backpressure: none; counts every clk edge.
module dmg_timer_div
  import dmg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       div_clr,
  input  logic [2:0] tac,
  output logic [7:0] div_hi,
  output logic       tick
);

  logic [15:0] div;
  logic        tap;
  logic        sig;
  logic        sig_q;

  // Divider: counts every edge, a DIV write zeroes all 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 16'h0000;
    end else if (div_clr) begin
      div <= 16'h0000;
    end else begin
      div <= div + 16'd1;
    end
  end

  // Tap mux: pick the divider bit that clocks TIMA
  always_comb begin
    tap = div[9];
    case (tac[1:0])
      TAC_SEL_DIV9: tap = div[9];
      TAC_SEL_DIV3: tap = div[3];
      TAC_SEL_DIV5: tap = div[5];
      TAC_SEL_DIV7: tap = div[7];
      default:      tap = div[9];
    endcase
  end

  // Enable is ANDed before the edge detector, so clearing DIV or TAC can
  // create a falling edge (hardware-accurate spurious tick).
  assign sig = tac[2] & tap;

  // Delay the gated tap by one edge for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign tick   = sig_q & ~sig;
  assign div_hi = div[15:8];

endmodule

// File: rtl/dmg_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC registers with delayed TIMA overflow reload and irq pulse.
// Latency: rdata combinational; TIMA reloads and irq pulses 4 edges after the wrap.
// Backpressure: none; writes are accepted on any edge.
module dmg_timer
  import dmg_timer_pkg::*;
#(
  parameter int INITIAL_ZERO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  // Pre-reset contents only matter in simulation; silicon state is defined
  // by reset, so the parameter selects no hardware.
  if (INITIAL_ZERO != 0) begin : g_initial_zero
  end

  logic [7:0] tima;
  logic [7:0] tma;
  logic [2:0] tac;
  logic [1:0] state;
  logic [1:0] cnt;

  logic [7:0] tima_nxt;
  logic [1:0] state_nxt;
  logic [1:0] cnt_nxt;
  logic       irq_nxt;

  logic [7:0] div_hi;
  logic       tick;
  logic       wr_div;
  logic       wr_tima;
  logic       wr_tma;
  logic       wr_tac;
  logic       reload_edge;

  assign wr_div  = wr && (addr == ADDR_DIV);
  assign wr_tima = wr && (addr == ADDR_TIMA);
  assign wr_tma  = wr && (addr == ADDR_TMA);
  assign wr_tac  = wr && (addr == ADDR_TAC);

  // The edge that leaves OVF is the reload edge: TMA wins over any TIMA write
  assign reload_edge = (state == ST_OVF) && (cnt == 2'd0);

  dmg_timer_div u_div (
    .clk     (clk),
    .reset   (reset),
    .div_clr (wr_div),
    .tac     (tac),
    .div_hi  (div_hi),
    .tick    (tick)
  );

  // Next-state for TIMA and the overflow FSM, with write priorities
  always_comb begin
    tima_nxt  = tima;
    state_nxt = state;
    cnt_nxt   = cnt;
    irq_nxt   = 1'b0;
    if (reload_edge) begin
      // A TMA write on this edge reaches TIMA directly
      tima_nxt  = wr_tma ? wdata : tma;
      state_nxt = ST_RELOAD;
      irq_nxt   = 1'b1;
    end else if (state == ST_OVF) begin
      cnt_nxt = cnt - 2'd1;
      if (wr_tima) begin
        // CPU write during the delay cancels the reload and the irq
        tima_nxt  = wdata;
        state_nxt = ST_IDLE;
      end else if (tick) begin
        tima_nxt = tima + 8'd1;
      end
    end else begin
      // IDLE and the single RELOAD cycle count normally
      state_nxt = ST_IDLE;
      if (wr_tima) begin
        tima_nxt = wdata;
      end else if (tick) begin
        tima_nxt = tima + 8'd1;
        if (tima == 8'hFF) begin
          state_nxt = ST_OVF;
          cnt_nxt   = OVF_CNT_INIT;
        end
      end
    end
  end

  // TIMA, FSM state, delay counter and irq registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tima  <= 8'h00;
      state <= ST_IDLE;
      cnt   <= 2'd0;
      irq   <= 1'b0;
    end else begin
      tima  <= tima_nxt;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      irq   <= irq_nxt;
    end
  end

  // TMA and TAC are plain loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tma <= 8'h00;
      tac <= 3'b000;
    end else begin
      if (wr_tma) tma <= wdata;
      if (wr_tac) tac <= wdata[2:0];
    end
  end

  // Combinational read mux; unused TAC bits read as ones
  always_comb begin
    rdata = div_hi;
    case (addr)
      ADDR_DIV:  rdata = div_hi;
      ADDR_TIMA: rdata = tima;
      ADDR_TMA:  rdata = tma;
      ADDR_TAC:  rdata = {5'b11111, tac};
      default:   rdata = div_hi;
    endcase
  end

endmodule
